// File: rtl/motion_system_core.sv
// motion_system_core
// Motion controller: PWM/H-bridge channels and quadrature-encoder channels
// behind a 32-bit register file. An external microcontroller reaches the
// register file over an asynchronous 8-bit two-wire-handshake byte bus.
// Each transaction is a 6-byte command packet followed by an 8-byte reply.
//
// Ports
//   CLOCK_50               system clock
//   async_uP_reset         synchronous active-low reset
//   quadrature_A/B/I       encoder phases and index, one bit per channel
//   async_uP_start         transaction start pulse (asynchronous)
//   async_uP_handshake_1   uP strobe (write bytes) / uP acknowledge (read bytes)
//   async_uP_RW            1 = uP drives uP_data, 0 = core may drive it
//   uP_ack                 1 = idle/complete, 0 = transaction in progress
//   uP_handshake_2         core acknowledge (write) / data-valid strobe (read)
//   uP_data                bidirectional byte bus
//   pwm_out                raw PWM per channel
//   H_bridge_1/2           H-bridge drive per channel
//   led1..led5             heartbeat, busy, last error, pwm_out[0], any QE enabled
//   test_pt1..test_pt4     synced start, synced handshake_1, uP_handshake_2, uP_ack
//
// Address decoding assumes NOS_PWM_CHANNELS <= 4 so the PWM block (8n) stays
// below the QE block (32+8n).
module motion_system_core #(
    parameter int NOS_PWM_CHANNELS = 4,
    parameter int NOS_WRITE_BYTES  = 8,
    parameter int HEARTBEAT_BITS   = 24
) (
    input  logic                        CLOCK_50,
    input  logic                        async_uP_reset,
    input  logic [NOS_PWM_CHANNELS-1:0] quadrature_A,
    input  logic [NOS_PWM_CHANNELS-1:0] quadrature_B,
    input  logic [NOS_PWM_CHANNELS-1:0] quadrature_I,
    input  logic                        async_uP_start,
    input  logic                        async_uP_handshake_1,
    input  logic                        async_uP_RW,
    output logic                        uP_ack,
    output logic                        uP_handshake_2,
    inout  wire  [7:0]                  uP_data,
    output logic [NOS_PWM_CHANNELS-1:0] pwm_out,
    output logic [NOS_PWM_CHANNELS-1:0] H_bridge_1,
    output logic [NOS_PWM_CHANNELS-1:0] H_bridge_2,
    output logic                        led1,
    output logic                        led2,
    output logic                        led3,
    output logic                        led4,
    output logic                        led5,
    output logic                        test_pt1,
    output logic                        test_pt2,
    output logic                        test_pt3,
    output logic                        test_pt4
);

    localparam int         N       = NOS_PWM_CHANNELS;
    localparam int         CH_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] LAST_RD = 4'(NOS_WRITE_BYTES - 1);
    localparam logic [7:0] PWM_END = 8'(8 * N);
    localparam logic [7:0] QE_BASE = 8'd32;
    localparam logic [7:0] QE_END  = 8'(32 + 8 * N);

    typedef enum logic [2:0] {
        IDLE, WR_WAIT_H1, WR_WAIT_H1_LOW, EXECUTE,
        RD_PRESENT, RD_WAIT_H1, RD_WAIT_H1_LOW, DONE
    } state_t;

    // x4 quadrature decode: {up, down} for one sampled A/B transition
    function automatic logic [1:0] qe_dir(input logic pa, input logic pb,
                                          input logic a, input logic b);
        case ({pa, pb, a, b})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: qe_dir = 2'b10;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: qe_dir = 2'b01;
            default:                            qe_dir = 2'b00;
        endcase
    endfunction

    state_t      state_r, state_next_s;
    logic [1:0]  start_sync_r, h1_sync_r, rw_sync_r;
    logic        start_prev_r;
    logic        start_s, h1_s, rw_s, start_rise_s, rd_phase_s;
    logic        ack_r, ack_next_s, hs2_r, hs2_next_s, settle_r, settle_next_s;
    logic [3:0]  idx_r, idx_next_s;
    logic [7:0]  cmd_r, addr_r;
    logic [31:0] wdata_r;
    logic [63:0] reply_r;
    logic        err_r, led1_r, led2_r, led5_r;
    logic [HEARTBEAT_BITS-1:0] hb_cnt_r;

    logic [31:0] pwm_period_r [N];
    logic [31:0] pwm_on_r     [N];
    logic [31:0] pwm_cfg_r    [N];
    logic [31:0] pwm_cnt_r    [N];
    logic [31:0] qe_cfg_r     [N];
    logic [31:0] qe_cpr_r     [N];
    logic [31:0] qe_count_r   [N];
    logic [31:0] qe_turns_r   [N];
    logic [N-1:0] pwm_s, pwm_r, h1_out_r, h2_out_r, qe_en_s;
    logic [N-1:0] qa_m_r, qa_r, qa_p_r, qb_m_r, qb_r, qb_p_r, qi_m_r, qi_r, qi_p_r;
    logic [1:0]   qe_step_s [N];

    logic            pwm_hit_s, qe_hit_s, mapped_s, ro_s, cmd_ok_s, err_s, wr_s;
    logic [CH_W-1:0] ch_s;
    logic [2:0]      off_s;
    logic [31:0]     rd_val_s, reply_data_s, status_s;

    assign start_s      = start_sync_r[1];
    assign h1_s         = h1_sync_r[1];
    assign rw_s         = rw_sync_r[1];
    assign start_rise_s = start_s & ~start_prev_r;
    assign rd_phase_s   = (state_r == RD_PRESENT) || (state_r == RD_WAIT_H1) ||
                          (state_r == RD_WAIT_H1_LOW);

    // The bus is released the moment the uP claims it, hence the raw RW here
    assign uP_data = (rd_phase_s && !async_uP_RW) ? reply_r[7:0] : 8'bz;

    assign uP_ack         = ack_r;
    assign uP_handshake_2 = hs2_r;
    assign pwm_out        = pwm_r;
    assign H_bridge_1     = h1_out_r;
    assign H_bridge_2     = h2_out_r;
    assign led1           = led1_r;
    assign led2           = led2_r;
    assign led3           = err_r;
    assign led4           = pwm_r[0];
    assign led5           = led5_r;
    assign test_pt1       = start_s;
    assign test_pt2       = h1_s;
    assign test_pt3       = hs2_r;
    assign test_pt4       = ack_r;

    // Two-stage synchronisers for the asynchronous bus controls
    always_ff @(posedge CLOCK_50) begin
        if (!async_uP_reset) begin
            start_sync_r <= 2'b00;
            h1_sync_r    <= 2'b00;
            rw_sync_r    <= 2'b00;
        end else begin
            start_sync_r <= {start_sync_r[0], async_uP_start};
            h1_sync_r    <= {h1_sync_r[0], async_uP_handshake_1};
            rw_sync_r    <= {rw_sync_r[0], async_uP_RW};
        end
    end

    // Bus FSM next-state and handshake outputs
    always_comb begin
        state_next_s  = state_r;
        ack_next_s    = ack_r;
        hs2_next_s    = hs2_r;
        idx_next_s    = idx_r;
        settle_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                ack_next_s = 1'b1;
                hs2_next_s = 1'b0;
                if (start_rise_s) begin
                    ack_next_s   = 1'b0;
                    idx_next_s   = 4'd0;
                    state_next_s = WR_WAIT_H1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WR_WAIT_H1: begin
                if (h1_s) begin
                    hs2_next_s   = 1'b1;
                    state_next_s = WR_WAIT_H1_LOW;
                end else begin
                    state_next_s = WR_WAIT_H1;
                end
            end
            WR_WAIT_H1_LOW: begin
                if (!h1_s) begin
                    hs2_next_s = 1'b0;
                    if (idx_r == 4'd5) begin
                        idx_next_s   = 4'd0;
                        state_next_s = EXECUTE;
                    end else begin
                        idx_next_s   = idx_r + 4'd1;
                        state_next_s = WR_WAIT_H1;
                    end
                end else begin
                    state_next_s = WR_WAIT_H1_LOW;
                end
            end
            EXECUTE: begin
                idx_next_s   = 4'd0;
                state_next_s = RD_PRESENT;
            end
            RD_PRESENT: begin
                // One settle clock between driving the byte and strobing it
                if (!rw_s) begin
                    if (settle_r) begin
                        hs2_next_s   = 1'b1;
                        state_next_s = RD_WAIT_H1;
                    end else begin
                        settle_next_s = 1'b1;
                    end
                end else begin
                    settle_next_s = 1'b0;
                end
            end
            RD_WAIT_H1: begin
                if (h1_s) begin
                    hs2_next_s   = 1'b0;
                    state_next_s = RD_WAIT_H1_LOW;
                end else begin
                    state_next_s = RD_WAIT_H1;
                end
            end
            RD_WAIT_H1_LOW: begin
                if (!h1_s) begin
                    if (idx_r == LAST_RD) begin
                        state_next_s = DONE;
                    end else begin
                        idx_next_s   = idx_r + 4'd1;
                        state_next_s = RD_PRESENT;
                    end
                end else begin
                    state_next_s = RD_WAIT_H1_LOW;
                end
            end
            DONE: begin
                ack_next_s   = 1'b1;
                hs2_next_s   = 1'b0;
                state_next_s = IDLE;
            end
            default: begin
                ack_next_s   = 1'b1;
                hs2_next_s   = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // Bus FSM state and handshake registers
    always_ff @(posedge CLOCK_50) begin
        if (!async_uP_reset) begin
            state_r      <= IDLE;
            ack_r        <= 1'b1;
            hs2_r        <= 1'b0;
            settle_r     <= 1'b0;
            idx_r        <= 4'd0;
            start_prev_r <= 1'b0;
            led2_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            ack_r        <= ack_next_s;
            hs2_r        <= hs2_next_s;
            settle_r     <= settle_next_s;
            idx_r        <= idx_next_s;
            start_prev_r <= start_s;
            led2_r       <= ~ack_next_s;
        end
    end

    // Address decode and read mux for the command being executed
    always_comb begin
        pwm_hit_s = (addr_r < PWM_END);
        qe_hit_s  = (addr_r >= QE_BASE) && (addr_r < QE_END);
        ch_s      = addr_r[3 +: CH_W];
        off_s     = addr_r[2:0];
        rd_val_s  = 32'd0;
        mapped_s  = 1'b0;
        ro_s      = 1'b0;
        if (pwm_hit_s) begin
            case (off_s)
                3'd0: begin rd_val_s = pwm_period_r[ch_s]; mapped_s = 1'b1; end
                3'd1: begin rd_val_s = pwm_on_r[ch_s];     mapped_s = 1'b1; end
                3'd2: begin rd_val_s = pwm_cfg_r[ch_s];    mapped_s = 1'b1; end
                3'd3: begin rd_val_s = 32'd0; mapped_s = 1'b1; ro_s = 1'b1; end
                default: begin mapped_s = 1'b0; end
            endcase
        end else if (qe_hit_s) begin
            case (off_s)
                3'd0: begin rd_val_s = qe_count_r[ch_s]; mapped_s = 1'b1; ro_s = 1'b1; end
                3'd1: begin rd_val_s = qe_turns_r[ch_s]; mapped_s = 1'b1; ro_s = 1'b1; end
                3'd2: begin rd_val_s = qe_cfg_r[ch_s];   mapped_s = 1'b1; end
                3'd3: begin rd_val_s = qe_cpr_r[ch_s];   mapped_s = 1'b1; end
                default: begin mapped_s = 1'b0; end
            endcase
        end else begin
            mapped_s = 1'b0;
        end
        cmd_ok_s     = (cmd_r == 8'd0) || (cmd_r == 8'd1);
        err_s        = !cmd_ok_s || !mapped_s || ((cmd_r == 8'd1) && ro_s);
        wr_s         = (state_r == EXECUTE) && (cmd_r == 8'd1) && !err_s;
        reply_data_s = err_s ? 32'd0 : ((cmd_r == 8'd1) ? wdata_r : rd_val_s);
        status_s     = {8'd0, cmd_r, addr_r, 7'd0, err_s};
    end

    // Command capture, reply shifter and writable register file
    always_ff @(posedge CLOCK_50) begin
        if (!async_uP_reset) begin
            cmd_r   <= 8'd0;
            addr_r  <= 8'd0;
            wdata_r <= 32'd0;
            reply_r <= 64'd0;
            err_r   <= 1'b0;
            for (int n = 0; n < N; n++) begin
                pwm_period_r[n] <= 32'd0;
                pwm_on_r[n]     <= 32'd0;
                pwm_cfg_r[n]    <= 32'd0;
                qe_cfg_r[n]     <= 32'd0;
                qe_cpr_r[n]     <= 32'd0;
            end
        end else begin
            if ((state_r == WR_WAIT_H1) && h1_s) begin
                case (idx_r)
                    4'd0:    cmd_r          <= uP_data;
                    4'd1:    addr_r         <= uP_data;
                    4'd2:    wdata_r[7:0]   <= uP_data;
                    4'd3:    wdata_r[15:8]  <= uP_data;
                    4'd4:    wdata_r[23:16] <= uP_data;
                    4'd5:    wdata_r[31:24] <= uP_data;
                    default: cmd_r          <= cmd_r;
                endcase
            end
            if (state_r == EXECUTE) begin
                reply_r <= {status_s, reply_data_s};
                err_r   <= err_s;
            end else if ((state_r == RD_WAIT_H1_LOW) && !h1_s && (idx_r != LAST_RD)) begin
                reply_r <= {8'd0, reply_r[63:8]};
            end
            for (int n = 0; n < N; n++) begin
                if (wr_s && (ch_s == CH_W'(n))) begin
                    if (pwm_hit_s) begin
                        case (off_s)
                            3'd0:    pwm_period_r[n] <= wdata_r;
                            3'd1:    pwm_on_r[n]     <= wdata_r;
                            3'd2:    pwm_cfg_r[n]    <= wdata_r;
                            default: pwm_cfg_r[n]    <= pwm_cfg_r[n];
                        endcase
                    end
                    if (qe_hit_s) begin
                        case (off_s)
                            3'd2:    qe_cfg_r[n] <= wdata_r;
                            3'd3:    qe_cpr_r[n] <= wdata_r;
                            default: qe_cfg_r[n] <= qe_cfg_r[n];
                        endcase
                    end
                end
            end
        end
    end

    // PWM compare and per-channel quadrature step decode
    always_comb begin
        for (int n = 0; n < N; n++) begin
            pwm_s[n]     = pwm_cfg_r[n][0] && (pwm_cnt_r[n] < pwm_on_r[n]);
            qe_en_s[n]   = qe_cfg_r[n][0];
            qe_step_s[n] = qe_dir(qa_p_r[n], qb_p_r[n], qa_r[n], qb_r[n]);
        end
    end

    // PWM counters and registered PWM/H-bridge outputs
    always_ff @(posedge CLOCK_50) begin
        if (!async_uP_reset) begin
            pwm_r    <= '0;
            h1_out_r <= '0;
            h2_out_r <= '0;
            for (int n = 0; n < N; n++) begin
                pwm_cnt_r[n] <= 32'd0;
            end
        end else begin
            pwm_r <= pwm_s;
            for (int n = 0; n < N; n++) begin
                if (!pwm_cfg_r[n][0]) begin
                    pwm_cnt_r[n] <= 32'd0;
                end else if (pwm_cnt_r[n] >= (pwm_period_r[n] - 32'd1)) begin
                    pwm_cnt_r[n] <= 32'd0;
                end else begin
                    pwm_cnt_r[n] <= pwm_cnt_r[n] + 32'd1;
                end
                case (pwm_cfg_r[n][2:1])
                    2'b00:   begin h1_out_r[n] <= pwm_s[n]; h2_out_r[n] <= 1'b0;     end
                    2'b01:   begin h1_out_r[n] <= 1'b0;     h2_out_r[n] <= pwm_s[n]; end
                    2'b11:   begin h1_out_r[n] <= 1'b1;     h2_out_r[n] <= 1'b1;     end
                    default: begin h1_out_r[n] <= 1'b0;     h2_out_r[n] <= 1'b0;     end
                endcase
            end
        end
    end

    // Encoder synchronisers, position counters and turn counters
    always_ff @(posedge CLOCK_50) begin
        if (!async_uP_reset) begin
            {qa_m_r, qa_r, qa_p_r} <= '0;
            {qb_m_r, qb_r, qb_p_r} <= '0;
            {qi_m_r, qi_r, qi_p_r} <= '0;
            for (int n = 0; n < N; n++) begin
                qe_count_r[n] <= 32'd0;
                qe_turns_r[n] <= 32'd0;
            end
        end else begin
            qa_m_r <= quadrature_A; qa_r <= qa_m_r; qa_p_r <= qa_r;
            qb_m_r <= quadrature_B; qb_r <= qb_m_r; qb_p_r <= qb_r;
            qi_m_r <= quadrature_I; qi_r <= qi_m_r; qi_p_r <= qi_r;
            for (int n = 0; n < N; n++) begin
                if (qe_cfg_r[n][0]) begin
                    if (qe_cfg_r[n][1] && qi_r[n] && !qi_p_r[n]) begin
                        qe_count_r[n] <= 32'd0;
                    end else if (qe_step_s[n][1]) begin
                        // COUNTS_PER_REV of zero lets COUNT run free
                        if ((qe_cpr_r[n] != 32'd0) && (qe_count_r[n] >= qe_cpr_r[n] - 32'd1)) begin
                            qe_count_r[n] <= 32'd0;
                            qe_turns_r[n] <= qe_turns_r[n] + 32'd1;
                        end else begin
                            qe_count_r[n] <= qe_count_r[n] + 32'd1;
                        end
                    end else if (qe_step_s[n][0]) begin
                        if ((qe_cpr_r[n] != 32'd0) && (qe_count_r[n] == 32'd0)) begin
                            qe_count_r[n] <= qe_cpr_r[n] - 32'd1;
                            qe_turns_r[n] <= qe_turns_r[n] - 32'd1;
                        end else begin
                            qe_count_r[n] <= qe_count_r[n] - 32'd1;
                        end
                    end
                end
            end
        end
    end

    // Heartbeat divider and the QE-enabled indicator
    always_ff @(posedge CLOCK_50) begin
        if (!async_uP_reset) begin
            hb_cnt_r <= '0;
            led1_r   <= 1'b0;
            led5_r   <= 1'b0;
        end else begin
            hb_cnt_r <= hb_cnt_r + 1'b1;
            if (&hb_cnt_r) begin
                led1_r <= ~led1_r;
            end
            led5_r <= |qe_en_s;
        end
    end

endmodule

// File: tb/tb_motion_system_core.sv
module tb_motion_system_core;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] qa = '0, qb = '0, qi = '0;
    logic         start = 1'b0, h1 = 1'b0, rw = 1'b1;
    logic         tb_drive = 1'b0;
    logic [7:0]   tb_data = 8'h00;
    wire  [7:0]   uP_data;
    logic         uP_ack, uP_handshake_2;
    logic [N-1:0] pwm_out, H_bridge_1, H_bridge_2;
    logic         led1, led2, led3, led4, led5;
    logic         test_pt1, test_pt2, test_pt3, test_pt4;

    int tests = 0;
    int fails = 0;
    int qphase = 0;

    assign uP_data = tb_drive ? tb_data : 8'bz;

    always #10 clk = ~clk;

    motion_system_core #(.NOS_PWM_CHANNELS(N), .NOS_WRITE_BYTES(8), .HEARTBEAT_BITS(24)) dut (
        .CLOCK_50(clk), .async_uP_reset(rst_n),
        .quadrature_A(qa), .quadrature_B(qb), .quadrature_I(qi),
        .async_uP_start(start), .async_uP_handshake_1(h1), .async_uP_RW(rw),
        .uP_ack(uP_ack), .uP_handshake_2(uP_handshake_2), .uP_data(uP_data),
        .pwm_out(pwm_out), .H_bridge_1(H_bridge_1), .H_bridge_2(H_bridge_2),
        .led1(led1), .led2(led2), .led3(led3), .led4(led4), .led5(led5),
        .test_pt1(test_pt1), .test_pt2(test_pt2), .test_pt3(test_pt3), .test_pt4(test_pt4)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [31:0] exp_stat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_hs2(input logic v);
        int cyc = 0;
        while (uP_handshake_2 !== v && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (uP_handshake_2 !== v) begin
            tests++; fails++;
            $display("FAIL hs2_timeout: uP_handshake_2=%b, required %b", uP_handshake_2, v);
        end
    endtask

    task automatic wait_ack(input logic v);
        int cyc = 0;
        while (uP_ack !== v && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (uP_ack !== v) begin
            tests++; fails++;
            $display("FAIL ack_timeout: uP_ack=%b, required %b", uP_ack, v);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        tb_data  = b;
        tb_drive = 1'b1;
        rw       = 1'b1;
        @(negedge clk);
        h1 = 1'b1;
        wait_hs2(1'b1);
        h1 = 1'b0;
        wait_hs2(1'b0);
    endtask

    task automatic read_byte(output logic [7:0] b);
        tb_drive = 1'b0;
        rw       = 1'b0;
        wait_hs2(1'b1);
        b  = uP_data;
        h1 = 1'b1;
        wait_hs2(1'b0);
        h1 = 1'b0;
    endtask

    task automatic xact(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic [31:0] rstat);
        logic [63:0] r;
        logic [7:0]  b;
        r = 64'd0;
        pulse_start();
        wait_ack(1'b0);
        write_byte(cmd);
        write_byte(addr);
        write_byte(data[7:0]);
        write_byte(data[15:8]);
        write_byte(data[23:16]);
        write_byte(data[31:24]);
        for (int i = 0; i < 8; i++) begin
            read_byte(b);
            r[i*8 +: 8] = b;
        end
        wait_ack(1'b1);
        rdata = r[31:0];
        rstat = r[63:32];
    endtask

    function automatic logic [1:0] quad_pat(input int p);
        case (p)
            0:       quad_pat = 2'b00;
            1:       quad_pat = 2'b10;
            2:       quad_pat = 2'b11;
            3:       quad_pat = 2'b01;
            default: quad_pat = 2'b00;
        endcase
    endfunction

    task automatic quad_move(input int dir);
        logic [1:0] ab;
        qphase = (qphase + dir + 4) % 4;
        ab = quad_pat(qphase);
        qa[0] = ab[1];
        qb[0] = ab[0];
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd, st;
        int hi, lo, bad, h1hi, h2hi;
        logic prev, found;

        vecs[0]  = '{8'h01, 8'h00, 32'h1234ABCD, 32'h1234ABCD, 32'h00010000};
        vecs[1]  = '{8'h00, 8'h00, 32'h00000000, 32'h1234ABCD, 32'h00000000};
        vecs[2]  = '{8'h01, 8'h01, 32'd25,       32'd25,       32'h00010100};
        vecs[3]  = '{8'h01, 8'h00, 32'd100,      32'd100,      32'h00010000};
        vecs[4]  = '{8'h01, 8'h03, 32'd5,        32'd0,        32'h00010301};
        vecs[5]  = '{8'h05, 8'h00, 32'd7,        32'd0,        32'h00050001};
        vecs[6]  = '{8'h00, 8'hFF, 32'd0,        32'd0,        32'h0000FF01};
        vecs[7]  = '{8'h00, 8'h00, 32'd0,        32'd100,      32'h00000000};
        vecs[8]  = '{8'h01, 8'h09, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00010900};
        vecs[9]  = '{8'h00, 8'h09, 32'd0,        32'hDEADBEEF, 32'h00000900};
        vecs[10] = '{8'h01, 8'h2B, 32'h55,       32'h55,       32'h00012B00};
        vecs[11] = '{8'h00, 8'h04, 32'd0,        32'd0,        32'h00000401};
        vecs[12] = '{8'h00, 8'h20, 32'd0,        32'd0,        32'h00002000};
        vecs[13] = '{8'h01, 8'h20, 32'd9,        32'd0,        32'h00012001};
        vecs[14] = '{8'h00, 8'h40, 32'd0,        32'd0,        32'h00004001};

        // reset state
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_ack", {31'd0, uP_ack}, 32'd1);
        check("reset_hs2", {31'd0, uP_handshake_2}, 32'd0);
        check("reset_pwm_bridges", {20'd0, pwm_out, H_bridge_1, H_bridge_2}, 32'd0);
        check("reset_leds", {27'd0, led1, led2, led3, led4, led5}, 32'd0);
        check("reset_tp4", {31'd0, test_pt4}, 32'd1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // register-file vectors
        for (int i = 0; i < 15; i++) begin
            xact(vecs[i].cmd, vecs[i].addr, vecs[i].data, rd, st);
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            check($sformatf("vec%0d_status", i), st, vecs[i].exp_stat);
            check($sformatf("vec%0d_led3", i), {31'd0, led3}, {31'd0, vecs[i].exp_stat[0]});
            check($sformatf("vec%0d_ack", i), {31'd0, uP_ack}, 32'd1);
        end

        // PWM ch0 forward: 25 high / 75 low
        xact(8'h01, 8'h02, 32'd1, rd, st);
        check("pwm_cfg1_status", st, 32'h00010200);
        prev = pwm_out[0];
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (!prev && pwm_out[0]) found = 1'b1;
            prev = pwm_out[0];
        end
        check("pwm_rise_found", {31'd0, found}, 32'd1);
        hi = 0; lo = 0; bad = 0;
        while (pwm_out[0] && hi < 300) begin
            if (H_bridge_1[0] !== pwm_out[0] || H_bridge_2[0] !== 1'b0 || led4 !== pwm_out[0]) bad++;
            hi++;
            @(negedge clk);
        end
        while (!pwm_out[0] && lo < 300) begin
            if (H_bridge_1[0] !== pwm_out[0] || H_bridge_2[0] !== 1'b0 || led4 !== pwm_out[0]) bad++;
            lo++;
            @(negedge clk);
        end
        check("pwm_high_run", hi, 32'd25);
        check("pwm_low_run", lo, 32'd75);
        check("pwm_fwd_bridge", bad, 32'd0);

        // reverse mode
        xact(8'h01, 8'h02, 32'd3, rd, st);
        h1hi = 0; h2hi = 0; bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (H_bridge_1[0]) h1hi++;
            if (H_bridge_2[0]) h2hi++;
            if (H_bridge_2[0] !== pwm_out[0]) bad++;
        end
        check("rev_h2_high", h2hi, 32'd25);
        check("rev_h1_high", h1hi, 32'd0);
        check("rev_h2_follows", bad, 32'd0);

        // brake mode
        xact(8'h01, 8'h02, 32'd7, rd, st);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!(H_bridge_1[0] && H_bridge_2[0])) bad++;
        end
        check("brake_both_high", bad, 32'd0);

        // QE ch0
        xact(8'h01, 8'h23, 32'd100, rd, st);
        check("qe_cpr_status", st, 32'h00012300);
        xact(8'h01, 8'h22, 32'd1, rd, st);
        repeat (2) @(negedge clk);
        check("qe_led5", {31'd0, led5}, 32'd1);
        for (int s = 0; s < 101; s++) quad_move(1);
        xact(8'h00, 8'h20, 32'd0, rd, st);
        check("qe_fwd_count", rd, 32'd1);
        xact(8'h00, 8'h21, 32'd0, rd, st);
        check("qe_fwd_turns", rd, 32'd1);
        quad_move(-1);
        quad_move(-1);
        xact(8'h00, 8'h20, 32'd0, rd, st);
        check("qe_rev_count", rd, 32'd99);
        xact(8'h00, 8'h21, 32'd0, rd, st);
        check("qe_rev_turns", rd, 32'd0);

        // reset in the middle of the write packet
        pulse_start();
        wait_ack(1'b0);
        write_byte(8'h01);
        write_byte(8'h00);
        write_byte(8'h77);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_ack", {31'd0, uP_ack}, 32'd1);
        check("midrst_hs2", {31'd0, uP_handshake_2}, 32'd0);
        check("midrst_bridges", {20'd0, pwm_out, H_bridge_1, H_bridge_2}, 32'd0);
        check("midrst_led5", {31'd0, led5}, 32'd0);
        rst_n    = 1'b1;
        tb_drive = 1'b0;
        h1       = 1'b0;
        repeat (3) @(negedge clk);
        xact(8'h00, 8'h00, 32'd0, rd, st);
        check("postrst_period", rd, 32'd0);
        check("postrst_status", st, 32'h00000000);
        xact(8'h00, 8'h22, 32'd0, rd, st);
        check("postrst_qecfg", rd, 32'd0);
        xact(8'h01, 8'h00, 32'h000000A5, rd, st);
        check("postrst_write_data", rd, 32'h000000A5);
        check("postrst_write_status", st, 32'h00010000);
        check("postrst_ack", {31'd0, uP_ack}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/motion_system_core.md
Name: motion_system_core

Overview:
- Top-level FPGA motion controller with NOS_PWM_CHANNELS PWM/H-bridge channels and the same number of quadrature-encoder (QE) channels.
- All channels are configured through a 32-bit register file.
- The register file is accessed by an external microcontroller over an asynchronous 8-bit, two-wire-handshake byte bus.
- Each bus transaction is one 6-byte command packet followed by one 8-byte reply packet.

Parameters:
NOS_PWM_CHANNELS, 4, number of PWM channels and QE channels
NOS_WRITE_BYTES, 8, reply packet length in bytes (data[4] + status[4])
HEARTBEAT_BITS, 24, width of the led1 blink divider

Ports:
CLOCK_50  in  1  system clock, 50 MHz
async_uP_reset  in  1  reset, synchronous, active-low
quadrature_A/B/I  in  NOS_PWM_CHANNELS each  encoder phases A, B and index
async_uP_start  in  1  transaction start; asynchronous; pulse of at least 3 clocks
async_uP_handshake_1  in  1  uP strobe (write) / uP acknowledge (read); asynchronous
async_uP_RW  in  1  bus direction: 1 = uP drives uP_data, 0 = DUT may drive
uP_ack  out  1  1 = idle/transaction complete, 0 = transaction in progress
uP_handshake_2  out  1  DUT acknowledge (write) / DUT data-valid strobe (read)
uP_data  inout  8  bidirectional data bus
pwm_out  out  NOS_PWM_CHANNELS  raw PWM
H_bridge_1, H_bridge_2  out  NOS_PWM_CHANNELS each  H-bridge drive
led1..led5  out  1 each  status LEDs
test_pt1..test_pt4  out  1 each  debug outputs

Behaviour:
- Synchronisation: async_uP_start, async_uP_handshake_1 and async_uP_RW each pass through a 2-FF synchroniser. All decisions use the synchronised copies.
- Reset (async_uP_reset low at a clock edge) gives:
  - uP_ack=1, uP_handshake_2=0, uP_data=Z
  - all registers 0, all PWM/H-bridge outputs 0, all LEDs 0
  - FSM in IDLE
- Reset mid-transaction aborts the transaction and returns the FSM to IDLE.
- FSM states: IDLE, WR_WAIT_H1, WR_WAIT_H1_LOW, EXECUTE, RD_PRESENT, RD_WAIT_H1, RD_WAIT_H1_LOW, DONE.
- IDLE: uP_ack=1. A rising edge of synchronised start sets uP_ack=0, byte index=0, and goes to WR_WAIT_H1.
- Write bytes, 6 of them, in order: command, register address, data[7:0], data[15:8], data[23:16], data[31:24].
  - WR_WAIT_H1: when handshake_1=1, latch uP_data, set uP_handshake_2=1, go to WR_WAIT_H1_LOW.
  - WR_WAIT_H1_LOW: when handshake_1=0, set uP_handshake_2=0. After the 6th byte go to EXECUTE; otherwise return to WR_WAIT_H1.
- EXECUTE (1 clock):
  - Command 0 = READ_REGISTER: reply data = register contents.
  - Command 1 = WRITE_REGISTER: write the register, reply data = post-write register value.
  - Any other command, or an unmapped address: no write, reply data=0, error=1.
- Status word: bit0 = error, bits[15:8] = register address, bits[23:16] = command, all other bits 0.
- Read bytes, NOS_WRITE_BYTES of them, in order: data[7:0..31:24], then status[7:0..31:24].
  - RD_PRESENT: wait for RW=0. Drive the byte on uP_data, then after 1 clock set uP_handshake_2=1.
  - RD_WAIT_H1: when handshake_1=1, set uP_handshake_2=0.
  - RD_WAIT_H1_LOW: when handshake_1=0, advance. After the last byte go to DONE.
- uP_data is driven only in read states and only while raw async_uP_RW=0; otherwise it is Z.
- DONE: set uP_ack=1, release the bus, go to IDLE.
- A start edge arriving while not in IDLE is ignored.
- Register map (8-bit address):
  - PWM channel n base = 8n. Offsets: PWM_PERIOD=0, PWM_ON_TIME=1, PWM_CONFIG=2, PWM_STATUS=3 (read-only, 0).
  - QE channel n base = 32+8n. Offsets: QE_COUNT=0 (read-only), QE_TURNS=1 (read-only), QE_CONFIG=2, QE_COUNTS_PER_REV=3.
  - Writes to read-only registers set error=1 and leave the register unchanged.
- PWM channel:
  - 32-bit counter runs while CONFIG[0] (enable) =1. Counter wraps to 0 when counter >= PERIOD-1.
  - pwm = enable && counter < ON_TIME, so ON_TIME >= PERIOD gives 100% and ON_TIME=0 gives 0%.
  - Disabling clears the counter. Register changes take effect immediately.
  - CONFIG[2:1] selects H-bridge mode:
    - 00: H1=pwm, H2=0 (forward)
    - 01: H1=0, H2=pwm (reverse)
    - 10: H1=H2=0 (coast)
    - 11: H1=H2=1 (brake)
  - pwm_out = pwm.
- QE channel:
  - A, B and I are each 2-FF synchronised. Enabled by CONFIG[0]. x4 decode: any valid A/B transition counts ±1, A leading B = +1. Invalid double transitions are ignored.
  - COUNT is unsigned and wraps COUNTS_PER_REV-1 → 0 with TURNS+1, and 0 → COUNTS_PER_REV-1 with TURNS-1.
  - COUNTS_PER_REV=0 disables the wrap.
  - CONFIG[1]=1: a rising edge of I clears COUNT.
- LEDs:
  - led1: heartbeat, toggles every 2^HEARTBEAT_BITS clocks
  - led2: ~uP_ack
  - led3: error from the last transaction
  - led4: pwm_out[0]
  - led5: OR of the QE enables
- Test points: test_pt1 = synced start, test_pt2 = synced handshake_1, test_pt3 = uP_handshake_2, test_pt4 = uP_ack.

Test Plan:
- Write PWM_PERIOD(ch0, addr 0) = 0x1234ABCD → reply data 0x1234ABCD, status 0x00010000; uP_ack returns to 1.
- Write period=100, on_time=25, config=1 to ch0, then READ addr 0 → data 100. pwm_out[0] and H_bridge_1[0] run 25 clocks high / 75 low repeating; H_bridge_2[0]=0.
- Set ch0 config=3 → H_bridge_2[0] carries the PWM and H_bridge_1[0]=0. Config=7 → both bridge outputs 1.
- Command 5, or address 0xFF → status bit0=1, no register changes, led3=1.
- QE ch0: counts_per_rev=100, config=1; drive 101 forward quadrature steps → QE_COUNT=1, QE_TURNS=1. Drive 2 reverse steps → COUNT=99, TURNS=0.
- Assert reset mid-write at byte 3 → uP_ack=1, uP_handshake_2=0, registers 0; the next full transaction completes normally.
